// File: rtl/variable_latency_bank_adapter.sv
// Adapts a 1-cycle single-port SRAM bank to a valid/ready request/response interconnect port.
// Latency: read response 1 cycle after acceptance when the response buffer is empty, writes silent.
// Backpressure: reads stall while responses in flight plus buffered reach RespDepth; writes never stall.

module vlba_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_vld,
    input  logic [Width-1:0]             push_dat,
    input  logic                         pop_rdy,
    output logic [Width-1:0]             head_dat,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(Depth+1)-1:0]   count
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             do_pop;

    // Pointers wrap at Depth, so non-power-of-two depths are fine.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop_rdy & ~empty;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CntW'(Depth));
    assign count    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_vld, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module variable_latency_bank_adapter #(
    parameter int NumInLog2    = 5,
    parameter int AddrMemWidth = 12,
    parameter int DataWidth    = 32,
    parameter int BeWidth      = DataWidth / 8,
    parameter int RespDepth    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NumInLog2-1:0]    req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [NumInLog2-1:0]    resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);
    if (RespDepth < 1) begin : g_depth_check
        $fatal(1, "variable_latency_bank_adapter: RespDepth must be >= 1");
    end

    localparam int CntW = $clog2(RespDepth + 1);
    localparam int OutW = CntW + 1;

    typedef struct packed {
        logic [NumInLog2-1:0] ini;
        logic [DataWidth-1:0] rdata;
    } resp_t;

    logic                 inflight_q;
    logic [NumInLog2-1:0] meta_q;
    resp_t                rd_pair;
    resp_t                head_dat;
    resp_t                resp_sel;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [CntW-1:0]      fifo_count;
    logic [OutW-1:0]      outstanding;
    logic                 read_ok;
    logic                 rd_accept;
    logic                 push_vld;
    logic                 pop_rdy;

    // Credit check counts the read still inside the SRAM so a stalled
    // response can always land in the buffer; it ignores resp_ready_i on purpose.
    assign outstanding = OutW'(fifo_count) + OutW'(inflight_q);
    assign read_ok     = (outstanding < OutW'(RespDepth));
    assign req_ready_o = req_wen_i | read_ok;
    assign mem_req_o   = req_valid_i & req_ready_o;
    assign rd_accept   = mem_req_o & ~req_wen_i;

    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_tgt_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            meta_q     <= '0;
        end else begin
            inflight_q <= rd_accept;
            if (rd_accept) meta_q <= req_ini_addr_i;
        end
    end

    assign rd_pair.ini   = meta_q;
    assign rd_pair.rdata = mem_rdata_i;

    // SRAM data bypasses only when nothing older is queued; a bypass the
    // consumer refuses is parked in the buffer so it is never lost.
    assign push_vld = inflight_q & (~fifo_empty | ~resp_ready_i);
    assign pop_rdy  = ~fifo_empty & resp_ready_i;

    vlba_fifo #(
        .Width ($bits(resp_t)),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_vld (push_vld),
        .push_dat (rd_pair),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign resp_sel        = fifo_empty ? rd_pair : head_dat;
    assign resp_valid_o    = ~fifo_empty | inflight_q;
    assign resp_ini_addr_o = resp_sel.ini;
    assign resp_rdata_o    = resp_sel.rdata;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_vld && !pop_rdy && fifo_full));
endmodule

// File: doc/variable_latency_bank_adapter.md
VARIABLE_LATENCY_BANK_ADAPTER -- requirements
Module: variable_latency_bank_adapter

Interface
REQ-001 SHALL have parameter NumInLog2, default 5, width of the initiator index carried with each request.
REQ-002 SHALL have parameter AddrMemWidth, default 12, bank word-address width.
REQ-003 SHALL have parameter DataWidth, default 32, data word width.
REQ-004 SHALL have parameter BeWidth, default DataWidth/8, byte-enable width.
REQ-005 SHALL have parameter RespDepth, default 2, response buffer depth; values below 1 SHALL raise $fatal at elaboration.
REQ-006 SHALL have ports clk_i  in  1  clock; rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have ports req_valid_i in 1; req_ready_o out 1; req_ini_addr_i in NumInLog2; req_tgt_addr_i in AddrMemWidth; req_wen_i in 1 (1=write); req_wdata_i in DataWidth; req_be_i in BeWidth -- interconnect-side request.
REQ-008 SHALL have ports resp_valid_o out 1; resp_ready_i in 1; resp_ini_addr_o out NumInLog2; resp_rdata_o out DataWidth -- interconnect-side response.
REQ-009 SHALL have ports mem_req_o out 1; mem_we_o out 1; mem_addr_o out AddrMemWidth; mem_wdata_o out DataWidth; mem_be_o out BeWidth; mem_rdata_i in DataWidth -- single-port SRAM, read data valid exactly 1 cycle after mem_req_o with mem_we_o=0.

Function
REQ-010 Request handshake SHALL complete on req_valid_i & req_ready_o in the same rising edge; mem_req_o SHALL equal req_valid_i & req_ready_o combinationally.
REQ-011 mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o SHALL be direct copies of req_wen_i, req_tgt_addr_i, req_wdata_i, req_be_i.
REQ-012 Writes SHALL produce no response; reads SHALL produce exactly one response each, in acceptance order.
REQ-013 Outstanding count = inflight_q (1 bit, read issued last cycle) + fifo_count (0..RespDepth); both registered.
REQ-014 req_ready_o SHALL be 1 when req_wen_i=1, else 1 iff outstanding < RespDepth; req_ready_o SHALL NOT depend on resp_ready_i.
REQ-015 On read acceptance, req_ini_addr_i SHALL be captured in a meta register and inflight_q set for the following cycle only.
REQ-016 In the cycle inflight_q=1, the pair {meta, mem_rdata_i} SHALL be presented: if FIFO empty, bypassed to resp_* directly (resp_valid_o=1 in that cycle, i.e. 1-cycle read latency); otherwise pushed to the FIFO tail.
REQ-017 If bypassed and resp_ready_i=0, the pair SHALL be pushed into the FIFO (never dropped).
REQ-018 When FIFO non-empty, resp_valid_o=1 with the FIFO head; head SHALL pop on resp_valid_o & resp_ready_i; push and pop in the same cycle SHALL keep fifo_count unchanged.
REQ-019 resp_valid_o, once high, SHALL hold with stable resp_ini_addr_o/resp_rdata_o until resp_ready_i=1.
REQ-020 FIFO pointers SHALL wrap modulo RespDepth; overflow SHALL be impossible by REQ-014 and SHALL be covered by an assertion.
REQ-021 With RespDepth>=2 and resp_ready_i held 1, back-to-back reads SHALL be accepted every cycle; with RespDepth=1, at most one read every 2 cycles.

Reset
REQ-022 While rst_ni=0: fifo_count=0, pointers=0, inflight_q=0, meta=0; resp_valid_o=0, mem_req_o=req_valid_i (ready=1), resp_ini_addr_o/resp_rdata_o don't-care.
REQ-023 Reset asserted mid-operation SHALL discard buffered and in-flight responses; no response SHALL appear after reset release for pre-reset requests.

Verification
REQ-024 Read of addr 0x010, ini 3, resp_ready_i=1 -> mem_req_o=1 same cycle, resp_valid_o=1 next cycle with ini 3, rdata=mem contents.
REQ-025 Write addr 0x020 data 0xDEADBEEF be 0xF then read 0x020 -> rdata 0xDEADBEEF; write produces no resp_valid_o pulse.
REQ-026 RespDepth=2, resp_ready_i=0, 4 back-to-back reads -> 2 accepted, req_ready_o=0 for reads while writes still accepted; release ready -> 2 responses in order, then remaining reads accepted.
REQ-027 Streaming 16 reads, resp_ready_i=1, RespDepth=2 -> 16 accepts in 16 cycles, 16 responses, ini addresses in order.
REQ-028 Random resp_ready_i with FIFO full and simultaneous push/pop -> no loss, no reordering, resp payload stable while stalled.
REQ-029 rst_ni pulsed low with 2 responses buffered -> resp_valid_o=0 immediately and stays 0 until new read accepted.
